// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Holds the controller state encoding and the operand width default.
package serial_add_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell.
// Time-shared by the serial adder, one bit per cycle.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell walks the operands LSB first.
// Valid/ready on both sides; the result is held in DONE until taken.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic            carry_q;
    logic [WIDTH-1:0] sum_q;
    logic            cout_q;

    logic            load;
    logic            step;
    logic            last;
    logic            fa_a;
    logic            fa_b;
    logic            fa_sum;
    logic            fa_cout;

    assign fa_a = a_q[cnt_q];
    assign fa_b = b_q[cnt_q];

    full_adder u_fa (
        .a    (fa_a),
        .b    (fa_b),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Next-state and handshake decode; all outputs default low.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt_q == LAST) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture, per-bit sum write-back and carry chaining.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (load) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
        end else if (step) begin
            sum_q[cnt_q] <= fa_sum;
            carry_q      <= fa_cout;
            if (last) begin
                cout_q <= fa_cout;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks for the bit-serial adder controller.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       busy;

    int tests;
    int fails;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operand set at a falling edge in IDLE, then scramble
    // the inputs and wait for out_valid. lat counts cycles from the
    // accept cycle (0) to the first cycle with out_valid high.
    task automatic issue(input logic [7:0] aa, input logic [7:0] bb,
                         input logic c, output int lat);
        in_valid = 1'b1;
        a        = aa;
        b        = bb;
        cin      = c;
        @(negedge clk);
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        cin      = 1'($urandom);
        lat      = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        cin       = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            fails++;
            $display("FAIL reset_ctrl got rdy/vld/busy=%b want 100",
                     {in_ready, out_valid, busy});
        end
        tests++;
        if ({cout, sum} !== 9'h000) begin
            fails++;
            $display("FAIL reset_data got cout=%b sum=%h want 0/00",
                     cout, sum);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release got in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        int lat;
        issue(8'h5A, 8'h33, 1'b0, lat);
        tests++;
        if (lat !== 9) begin
            fails++;
            $display("FAIL basic_latency got %0d want 9", lat);
        end
        tests++;
        if ({cout, sum} !== {1'b0, 8'h8D}) begin
            fails++;
            $display("FAIL basic_sum got %b/%h want 0/8d", cout, sum);
        end
        tests++;
        if ({in_ready, busy} !== 2'b00) begin
            fails++;
            $display("FAIL basic_done_flags got rdy/busy=%b want 00",
                     {in_ready, busy});
        end
        retire();
    endtask

    task automatic test_ripple();
        int lat;
        issue(8'hFF, 8'h00, 1'b1, lat);
        tests++;
        if ({lat == 9, cout, sum} !== {1'b1, 1'b1, 8'h00}) begin
            fails++;
            $display("FAIL ripple got lat=%0d %b/%h want 9 1/00",
                     lat, cout, sum);
        end
        retire();
    endtask

    task automatic test_stall();
        int lat;
        issue(8'hFF, 8'hFF, 1'b1, lat);
        tests++;
        if ({lat == 9, cout, sum} !== {1'b1, 1'b1, 8'hFF}) begin
            fails++;
            $display("FAIL stall_sum got lat=%0d %b/%h want 9 1/ff",
                     lat, cout, sum);
        end
        in_valid = 1'b1;
        a        = 8'h12;
        b        = 8'h34;
        cin      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if ({out_valid, in_ready, cout, sum} !== {3'b101, 8'hFF}) begin
                fails++;
                $display("FAIL stall_hold%0d got v/r/c/s=%b%b%b/%h want 101/ff",
                         i, out_valid, in_ready, cout, sum);
            end
        end
        in_valid = 1'b0;
        retire();
        tests++;
        if ({out_valid, in_ready, cout, sum} !== {3'b011, 8'hFF}) begin
            fails++;
            $display("FAIL stall_retain got v/r/c/s=%b%b%b/%h want 011/ff",
                     out_valid, in_ready, cout, sum);
        end
    endtask

    task automatic test_back_to_back();
        int acc1;
        int acc2;
        int hs1;
        int hs2;
        logic [8:0] r1;
        logic [8:0] r2;
        acc1 = -1;
        acc2 = -1;
        hs1  = -1;
        hs2  = -1;
        r1   = '0;
        r2   = '0;
        in_valid  = 1'b1;
        a         = 8'h01;
        b         = 8'h01;
        cin       = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 30; t++) begin
            if (in_valid && in_ready) begin
                if (acc1 < 0) acc1 = t;
                else if (acc2 < 0) acc2 = t;
            end
            if (out_valid && out_ready) begin
                if (hs1 < 0) begin
                    hs1 = t;
                    r1  = {cout, sum};
                end else if (hs2 < 0) begin
                    hs2 = t;
                    r2  = {cout, sum};
                end
            end
            @(posedge clk);
            #1;
            if (acc1 >= 0) begin
                a = 8'h80;
                b = 8'h80;
            end
            if (acc2 >= 0) in_valid = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b0;
        tests++;
        if (hs1 !== 9) begin
            fails++;
            $display("FAIL b2b_first_hs got cycle %0d want 9", hs1);
        end
        tests++;
        if (acc2 - hs1 !== 1) begin
            fails++;
            $display("FAIL b2b_gap got %0d want 1 (acc1=%0d acc2=%0d)",
                     acc2 - hs1, acc1, acc2);
        end
        tests++;
        if (r1 !== 9'h002) begin
            fails++;
            $display("FAIL b2b_res1 got %h want 002", r1);
        end
        tests++;
        if (r2 !== 9'h100 || hs2 !== 19) begin
            fails++;
            $display("FAIL b2b_res2 got %h at %0d want 100 at 19", r2, hs2);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen;
        in_valid = 1'b1;
        a        = 8'h77;
        b        = 8'h11;
        cin      = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_busy got %b want 1", busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests++;
        if ({in_ready, busy, out_valid, cout, sum} !== {4'b1000, 8'h00}) begin
            fails++;
            $display("FAIL abort_idle got r/b/v/c/s=%b%b%b%b/%h want 1000/00",
                     in_ready, busy, out_valid, cout, sum);
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL abort_no_valid got %0d cycles want 0", seen);
        end
        issue(8'h10, 8'h10, 1'b0, lat);
        tests++;
        if ({lat == 9, cout, sum} !== {1'b1, 1'b0, 8'h20}) begin
            fails++;
            $display("FAIL abort_next got lat=%0d %b/%h want 9 0/20",
                     lat, cout, sum);
        end
        retire();
    endtask

    task automatic test_random();
        int lat;
        int k;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] exp_r;
        for (int n = 0; n < 1000; n++) begin
            ra    = 8'($urandom);
            rb    = 8'($urandom);
            rc    = 1'($urandom);
            exp_r = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            issue(ra, rb, rc, lat);
            k = $urandom_range(0, 3);
            repeat (k) @(negedge clk);
            tests++;
            if ({cout, sum} !== exp_r) begin
                fails++;
                $display("FAIL rand%0d %h+%h+%b got %h want %h",
                         n, ra, rb, rc, {cout, sum}, exp_r);
            end
            tests++;
            if (lat !== 9) begin
                fails++;
                $display("FAIL rand%0d_latency got %0d want 9", n, lat);
            end
            retire();
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_ripple();
        test_stall();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand set.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: the addends.
REQ-007 The block SHALL have port cin, input, 1 bit: the carry-in of the addition.
REQ-008 The block SHALL have port out_valid, output, 1 bit: sum and cout are valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port sum, output, WIDTH bits: the result, equal to (a+b+cin) mod 2^WIDTH.
REQ-011 The block SHALL have port cout, output, 1 bit: the carry out of bit WIDTH-1.
REQ-012 The block SHALL have port busy, output, 1 bit: high while the FSM is in RUN.

Function
REQ-013 The block SHALL use one full-adder cell, time-shared across bits (bit-serial, LSB first).
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE the block SHALL drive in_ready=1, and in every other state in_ready=0.
REQ-016 The handshake in_valid&&in_ready SHALL capture a, b and cin into shift/carry registers, clear the bit counter and move to RUN.
REQ-017 In RUN, each cycle SHALL feed bit[cnt] of a and b plus the carry register to the cell, store the cell sum in sum[cnt] and the cell carry in the carry register, then increment cnt.
REQ-018 When cnt==WIDTH-1 in RUN, the block SHALL store the final bit, load the cell carry into cout and move to DONE.
REQ-019 Latency: out_valid SHALL rise exactly WIDTH+1 cycles after the accepting edge (WIDTH RUN cycles, then DONE).
REQ-020 In DONE, out_valid SHALL be 1, with sum and cout held stable until out_valid&&out_ready.
REQ-021 On out_valid&&out_ready the FSM SHALL move to IDLE; a new operand SHALL NOT be accepted in that same cycle (minimum issue interval WIDTH+2 cycles).
REQ-022 out_ready asserted before DONE SHALL have no effect, and out_ready held low SHALL stall indefinitely in DONE.
REQ-023 Changes on a, b or cin after acceptance SHALL NOT affect the result in flight.
REQ-024 in_valid in RUN or DONE SHALL be ignored, with no capture and no error.
REQ-025 sum and cout SHALL retain the last result after leaving DONE until the next RUN overwrites them.

Reset
REQ-026 With rst_n=0 at a clock edge, the block SHALL enter IDLE and set cnt=0, carry=0, sum=0, cout=0, out_valid=0 and busy=0; in_ready SHALL be 1 from the first edge after release.
REQ-027 Reset asserted in RUN or DONE SHALL abort the operation, with no out_valid produced for it.
REQ-028 Reset SHALL take priority over every handshake in the same cycle.

Structure
REQ-029 The state enum (IDLE/RUN/DONE) and the WIDTH default SHALL live in the shared package serial_add_pkg.
REQ-030 The cell SHALL be the existing full_adder module (ports a, b, cin, sum, cout), instantiated once, with no other sub-modules.
REQ-031 cnt SHALL be $clog2(WIDTH) bits wide, with no wrap beyond WIDTH-1.

Verification
REQ-032 WIDTH=8: a=0x5A, b=0x33, cin=0 -> out_valid at +9 cycles, sum=0x8D, cout=0.
REQ-033 a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1 (full carry ripple).
REQ-034 a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1; then hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0 throughout.
REQ-035 in_valid held high with back-to-back operands (0x01+0x01, then 0x80+0x80) -> second accept exactly 1 cycle after the first result handshake; results 0x02/0 and 0x00/1.
REQ-036 rst_n=0 for 1 cycle at RUN cnt=4 -> IDLE next cycle, out_valid never asserted, next op 0x10+0x10 gives 0x20, cout=0.
REQ-037 A scoreboard SHALL run 1000 random operand/cin/out_ready-stall cases and check sum and cout against a+b+cin.
